// File: rtl/sdram_cmd_seq_pkg.sv
// Shared definitions for the SDRAM command sequencer: state codes, command codes,
// strobe encodings and datapath widths.
package sdram_cmd_seq_pkg;

    localparam int unsigned CMD_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned CS_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_INIT  = 3'd1,
        ST_WAIT_READY = 3'd2,
        ST_ISSUE      = 3'd3,
        ST_WAIT_ACK   = 3'd4,
        ST_WAIT_DONE  = 3'd5,
        ST_DONE       = 3'd6,
        ST_ERROR      = 3'd7
    } state_e;

    localparam logic [CMD_W-1:0] CMD_READ_CODE  = 4'd8;
    localparam logic [CMD_W-1:0] CMD_WRITE_CODE = 4'd9;

    localparam logic [CS_W-1:0] CS_STROBE = 2'b01;
    localparam logic [CS_W-1:0] CS_IDLE   = 2'b00;

endpackage

// File: rtl/seg7_dec.sv
// Hex digit to 7-segment decoder; segments ordered {g,f,e,d,c,b,a}, active-low.
module seg7_dec
    import sdram_cmd_seq_pkg::*;
(
    input  logic [3:0]       val_i,
    output logic [SEG_W-1:0] seg_o
);

    logic [SEG_W-1:0] seg_on;

    // Active-high pattern first, inverted once at the output.
    always_comb begin
        seg_on = 7'h00;
        case (val_i)
            4'h0: seg_on = 7'h3F;
            4'h1: seg_on = 7'h06;
            4'h2: seg_on = 7'h5B;
            4'h3: seg_on = 7'h4F;
            4'h4: seg_on = 7'h66;
            4'h5: seg_on = 7'h6D;
            4'h6: seg_on = 7'h7D;
            4'h7: seg_on = 7'h07;
            4'h8: seg_on = 7'h7F;
            4'h9: seg_on = 7'h6F;
            4'hA: seg_on = 7'h77;
            4'hB: seg_on = 7'h7C;
            4'hC: seg_on = 7'h39;
            4'hD: seg_on = 7'h5E;
            4'hE: seg_on = 7'h79;
            4'hF: seg_on = 7'h71;
            default: seg_on = 7'h00;
        endcase
    end

    assign seg_o = ~seg_on;

endmodule

// File: rtl/sdram_cmd_seq.sv
// Issues NUM_CMDS alternating write/read commands to an SDRAM controller per go edge,
// with a per-state handshake timeout and 7-segment status readout.
module sdram_cmd_seq
    import sdram_cmd_seq_pkg::*;
#(
    parameter int unsigned      NUM_CMDS  = 8,
    parameter int unsigned      TIMEOUT   = 200,
    parameter logic [CMD_W-1:0] CMD_READ  = CMD_READ_CODE,
    parameter logic [CMD_W-1:0] CMD_WRITE = CMD_WRITE_CODE
) (
    input  logic             clk,
    input  logic             switch,
    input  logic             go,
    input  logic             init_comp,
    input  logic             reply,
    output logic [CMD_W-1:0] cmd,
    output logic [CS_W-1:0]  cmd_sent,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [SEG_W-1:0] hex1,
    output logic [SEG_W-1:0] hex2
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_CMDS - 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             go_q;
    logic             arm_q, arm_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [CS_W-1:0]  cmd_sent_q, cmd_sent_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             tmo_hit;
    logic             go_rise;

    assign tmo_hit = (tmo_q == TMO_LIMIT);
    // arm_q blocks a go level held through reset from counting as a fresh edge.
    assign go_rise = go && !go_q && arm_q;

    always_comb begin
        state_d = state_q;
        arm_d   = arm_q | ~go;
        step_d  = step_q;
        count_d = count_q;
        tmo_d   = tmo_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (go_rise) begin
                    state_d = ST_WAIT_INIT;
                    step_d  = '0;
                    count_d = '0;
                end
            end
            ST_WAIT_INIT: begin
                if (!go) begin
                    state_d = ST_IDLE;
                end else if (init_comp) begin
                    state_d = ST_WAIT_READY;
                    tmo_d   = '0;
                end
            end
            ST_WAIT_READY: begin
                if (!init_comp)   state_d = ST_ERROR;
                else if (!go)     state_d = ST_IDLE;
                else if (reply)   state_d = ST_ISSUE;
                else if (tmo_hit) state_d = ST_ERROR;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_ACK;
                tmo_d   = '0;
            end
            ST_WAIT_ACK: begin
                if (!init_comp) begin
                    state_d = ST_ERROR;
                end else if (!reply) begin
                    state_d = ST_WAIT_DONE;
                    tmo_d   = '0;
                end else if (tmo_hit) begin
                    state_d = ST_ERROR;
                end
            end
            ST_WAIT_DONE: begin
                if (!init_comp) begin
                    state_d = ST_ERROR;
                end else if (reply) begin
                    count_d = count_q + CNT_W'(1);
                    step_d  = step_q + CNT_W'(1);
                    // A dropped go lets the in-flight command finish but never reports done.
                    if (!go) begin
                        state_d = ST_IDLE;
                    end else if (step_q == LAST_STEP) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_READY;
                        tmo_d   = '0;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (!go) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_d      = cmd_q;
        cmd_sent_d = CS_IDLE;
        if (state_d == ST_ISSUE) begin
            cmd_d      = step_q[0] ? CMD_READ : CMD_WRITE;
            cmd_sent_d = CS_STROBE;
        end
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE) && (state_d != ST_ERROR);
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge switch) begin
        if (!switch) begin
            state_q    <= ST_IDLE;
            go_q       <= 1'b0;
            arm_q      <= 1'b0;
            step_q     <= '0;
            count_q    <= '0;
            tmo_q      <= '0;
            cmd_q      <= '0;
            cmd_sent_q <= CS_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            go_q       <= go;
            arm_q      <= arm_d;
            step_q     <= step_d;
            count_q    <= count_d;
            tmo_q      <= tmo_d;
            cmd_q      <= cmd_d;
            cmd_sent_q <= cmd_sent_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cmd      = cmd_q;
    assign cmd_sent = cmd_sent_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

    seg7_dec u_hex1 (
        .val_i (count_q[3:0]),
        .seg_o (hex1)
    );

    seg7_dec u_hex2 (
        .val_i ({1'b0, state_q}),
        .seg_o (hex2)
    );

endmodule

// File: tb/tb_sdram_cmd_seq.sv
// Self-checking bench for sdram_cmd_seq: a 4-command and a 255-command instance share stimulus;
// a strobe monitor pops expected command codes from a scoreboard queue.
module tb_sdram_cmd_seq;

    logic       clk;
    logic       switch;
    logic       go;
    logic       init_comp;
    logic       reply;

    logic [3:0] n_cmd, w_cmd;
    logic [1:0] n_cs, w_cs;
    logic       n_busy, n_done, n_err, w_busy, w_done, w_err;
    logic [6:0] n_hex1, n_hex2, w_hex1, w_hex2;

    bit         sel_w;
    logic [1:0] cs_sel;
    logic [3:0] cmd_sel;

    int         checks;
    int         failures;
    logic [3:0] exp_q[$];

    typedef struct {
        int         ack_dly;
        int         done_dly;
        logic [3:0] exp_cmd;
        int         exp_count;
        int         exp_state;
        int         exp_done;
    } vec_t;

    vec_t vecs[4];

    sdram_cmd_seq #(.NUM_CMDS(4), .TIMEOUT(10)) dut_n (
        .clk(clk), .switch(switch), .go(go), .init_comp(init_comp), .reply(reply),
        .cmd(n_cmd), .cmd_sent(n_cs), .busy(n_busy), .done(n_done), .err(n_err),
        .hex1(n_hex1), .hex2(n_hex2)
    );

    sdram_cmd_seq #(.NUM_CMDS(255), .TIMEOUT(10)) dut_w (
        .clk(clk), .switch(switch), .go(go), .init_comp(init_comp), .reply(reply),
        .cmd(w_cmd), .cmd_sent(w_cs), .busy(w_busy), .done(w_done), .err(w_err),
        .hex1(w_hex1), .hex2(w_hex2)
    );

    assign cs_sel  = sel_w ? w_cs  : n_cs;
    assign cmd_sel = sel_w ? w_cmd : n_cmd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_exp(input int v);
        case (v & 15)
            0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
            4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
            8: return 7'h00;   9: return 7'h10;   10: return 7'h08;  11: return 7'h03;
            12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    // Scoreboard: every strobe on the selected instance must match the oldest expected code.
    always @(negedge clk) begin
        logic [3:0] e;
        if (switch && cs_sel !== 2'b00) begin
            if (cs_sel !== 2'b01) begin
                check("cmd_sent_enc", int'(cs_sel), 1);
            end else if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got strobe with cmd %0d, expected no strobe", cmd_sel);
            end else begin
                e = exp_q.pop_front();
                check("cmd_code", int'(cmd_sel), int'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (cs_sel == 2'b01) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Controller model: drop reply ack_dly cycles after the strobe, raise it done_dly cycles later.
    task automatic handshake(input int ack_dly, input int done_dly, output bit ok);
        wait_strobe(20, ok);
        if (ok) begin
            repeat (ack_dly) tick();
            reply = 1'b0;
            repeat (done_dly) tick();
            reply = 1'b1;
            tick();
        end
    endtask

    task automatic do_reset();
        switch    = 1'b0;
        go        = 1'b0;
        reply     = 1'b1;
        init_comp = 1'b1;
        repeat (2) tick();
        switch = 1'b1;
        repeat (2) tick();
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bit bad;
        int n;

        checks   = 0;
        failures = 0;
        sel_w    = 1'b0;
        vecs[0] = '{1, 3, 4'd9, 1, 2, 0};
        vecs[1] = '{1, 3, 4'd8, 2, 2, 0};
        vecs[2] = '{2, 1, 4'd9, 3, 2, 0};
        vecs[3] = '{1, 5, 4'd8, 4, 6, 1};

        switch = 1'b0; go = 1'b0; init_comp = 1'b0; reply = 1'b0;
        repeat (2) tick();
        check("rst_cmd", int'(n_cmd), 0);
        check("rst_cmd_sent", int'(n_cs), 0);
        check("rst_busy", int'(n_busy), 0);
        check("rst_done", int'(n_done), 0);
        check("rst_err", int'(n_err), 0);
        check("rst_hex1", int'(n_hex1), int'(seg_exp(0)));
        check("rst_hex2", int'(n_hex2), int'(seg_exp(0)));

        // Normal 4-command run, table driven.
        do_reset();
        go = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(vecs[i].exp_cmd);
            handshake(vecs[i].ack_dly, vecs[i].done_dly, ok);
            check("norm_strobe", int'(ok), 1);
            check("norm_hex1", int'(n_hex1), int'(seg_exp(vecs[i].exp_count)));
            check("norm_hex2", int'(n_hex2), int'(seg_exp(vecs[i].exp_state)));
            check("norm_done", int'(n_done), vecs[i].exp_done);
            check("norm_busy", int'(n_busy), 1 - vecs[i].exp_done);
        end
        repeat (5) tick();
        check("norm_queue_empty", exp_q.size(), 0);
        check("norm_cmd_hold", int'(n_cmd), 8);
        check("norm_done_sticky", int'(n_done), 1);
        go = 1'b0;
        tick();
        check("norm_done_clr", int'(n_done), 0);
        check("norm_idle", int'(n_hex2), int'(seg_exp(0)));

        // Long init wait, then timeout on a stuck reply.
        do_reset();
        init_comp = 1'b0;
        go = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 15000; i++) begin
            tick();
            if (n_cs !== 2'b00 || n_err !== 1'b0) bad = 1'b1;
        end
        check("init_quiet", int'(bad), 0);
        check("init_state", int'(n_hex2), int'(seg_exp(1)));
        exp_q.push_back(4'd9);
        init_comp = 1'b1;
        wait_strobe(3, ok);
        check("init_first_strobe", int'(ok), 1);
        n = 0;
        while (n_err !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, 11);
        check("tmo_err", int'(n_err), 1);
        check("tmo_hex2", int'(n_hex2), int'(seg_exp(7)));
        check("tmo_busy", int'(n_busy), 0);
        repeat (5) tick();
        check("tmo_queue_empty", exp_q.size(), 0);
        go = 1'b0;
        tick();
        check("tmo_err_clr", int'(n_err), 0);
        check("tmo_idle", int'(n_hex2), int'(seg_exp(0)));

        // Asynchronous reset while waiting for the controller ack.
        do_reset();
        go = 1'b1;
        exp_q.push_back(4'd9);
        wait_strobe(5, ok);
        check("arst_strobe", int'(ok), 1);
        tick();
        switch = 1'b0;
        #1;
        check("arst_cmd", int'(n_cmd), 0);
        check("arst_cmd_sent", int'(n_cs), 0);
        check("arst_busy", int'(n_busy), 0);
        check("arst_hex2", int'(n_hex2), int'(seg_exp(0)));
        repeat (2) tick();
        switch = 1'b1;
        repeat (20) tick();
        check("arst_no_restart", int'(n_hex2), int'(seg_exp(0)));
        check("arst_busy_after", int'(n_busy), 0);
        go = 1'b0;
        tick();
        go = 1'b1;
        exp_q.push_back(4'd9);
        wait_strobe(5, ok);
        check("arst_fresh_go", int'(ok), 1);
        tick();
        check("arst_queue_empty", exp_q.size(), 0);

        // go dropped during WAIT_DONE of step 1 on the 255-command instance.
        sel_w = 1'b1;
        do_reset();
        go = 1'b1;
        exp_q.push_back(4'd9);
        handshake(1, 3, ok);
        check("drop_strobe0", int'(ok), 1);
        check("drop_hex1_1", int'(w_hex1), int'(seg_exp(1)));
        exp_q.push_back(4'd8);
        wait_strobe(10, ok);
        check("drop_strobe1", int'(ok), 1);
        tick();
        reply = 1'b0;
        tick();
        go = 1'b0;
        repeat (2) tick();
        reply = 1'b1;
        tick();
        check("drop_hex1_2", int'(w_hex1), int'(seg_exp(2)));
        check("drop_idle", int'(w_hex2), int'(seg_exp(0)));
        check("drop_done", int'(w_done), 0);
        check("drop_busy", int'(w_busy), 0);
        repeat (20) tick();
        check("drop_queue_empty", exp_q.size(), 0);

        // 255-command run, then a second run restarting the count.
        do_reset();
        go = 1'b1;
        for (int i = 0; i < 255; i++) begin
            exp_q.push_back((i % 2) ? 4'd8 : 4'd9);
            handshake(1, 1, ok);
            check("wrap_strobe", int'(ok), 1);
            check("wrap_hex1", int'(w_hex1), int'(seg_exp(i + 1)));
            if (!ok) break;
        end
        check("wrap_done", int'(w_done), 1);
        check("wrap_hex1_F", int'(w_hex1), int'(seg_exp(15)));
        check("wrap_hex2", int'(w_hex2), int'(seg_exp(6)));
        go = 1'b0;
        tick();
        go = 1'b1;
        tick();
        check("rerun_hex1_clr", int'(w_hex1), int'(seg_exp(0)));
        check("rerun_hex2", int'(w_hex2), int'(seg_exp(1)));
        exp_q.push_back(4'd9);
        handshake(1, 1, ok);
        check("rerun_strobe", int'(ok), 1);
        check("rerun_hex1", int'(w_hex1), int'(seg_exp(1)));
        check("rerun_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
